// File: rtl/flow_ctrl.sv
// Pipeline flow controller for the 5-stage core: D-cache freezes, I-cache miss
// holds, load-use bubbles and EX redirects, plus a miss watchdog and stall counter.
module flow_ctrl #(
  parameter int MISS_TIMEOUT = 1024,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_branch_taken_i,
  input  logic             ex_jump_i,
  input  logic [31:0]      ex_target_i,
  input  logic             ex_is_load_i,
  input  logic [4:0]       ex_rd_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_rs1_used_i,
  input  logic             id_rs2_used_i,
  input  logic             mem_dc_miss_i,
  input  logic             dc_refill_done_i,
  input  logic             ic_miss_i,
  input  logic             ic_refill_done_i,
  output logic             fc_hold_pc_o,
  output logic             fc_hold_if_id_o,
  output logic             fc_hold_id_ex_o,
  output logic             fc_hold_ex_mem_o,
  output logic             fc_bubble_id_ex_o,
  output logic             fc_flush_btype_flag_o,
  output logic             fc_flush_jtype_flag_o,
  output logic [31:0]      fc_redirect_pc_o,
  output logic             fc_ic_cancel_o,
  output logic             fc_err_o,
  output logic [CNT_W-1:0] fc_stall_cnt_o,
  output logic [1:0]       fc_state_o
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DMISS = 2'd1,
    IMISS = 2'd2
  } state_t;

  localparam int WD_W = $clog2(MISS_TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(MISS_TIMEOUT);

  state_t          state;
  state_t          state_nxt;
  logic [WD_W-1:0] wd_cnt;
  logic            redirect;
  logic            load_use;
  logic            any_hold;

  assign redirect = ex_branch_taken_i || ex_jump_i;
  assign load_use = ex_is_load_i && (ex_rd_i != 5'd0) &&
                    ((id_rs1_used_i && (id_rs1_i == ex_rd_i)) ||
                     (id_rs2_used_i && (id_rs2_i == ex_rd_i)));
  assign any_hold = fc_hold_pc_o || fc_hold_if_id_o || fc_hold_id_ex_o || fc_hold_ex_mem_o;
  assign fc_state_o = state;

  // Controls are gated by rst_n so the pipeline sees all-zero while reset is held.
  always_comb begin
    state_nxt             = state;
    fc_hold_pc_o          = 1'b0;
    fc_hold_if_id_o       = 1'b0;
    fc_hold_id_ex_o       = 1'b0;
    fc_hold_ex_mem_o      = 1'b0;
    fc_bubble_id_ex_o     = 1'b0;
    fc_flush_btype_flag_o = 1'b0;
    fc_flush_jtype_flag_o = 1'b0;
    fc_redirect_pc_o      = 32'h0;
    fc_ic_cancel_o        = 1'b0;
    if (rst_n) begin
      case (state)
        RUN: begin
          if (mem_dc_miss_i) begin
            // EX is frozen, so any pending redirect is re-presented after the refill.
            {fc_hold_pc_o, fc_hold_if_id_o, fc_hold_id_ex_o, fc_hold_ex_mem_o} = 4'b1111;
            state_nxt = DMISS;
          end else if (redirect) begin
            fc_flush_btype_flag_o = ex_branch_taken_i;
            fc_flush_jtype_flag_o = !ex_branch_taken_i;
            fc_redirect_pc_o      = ex_target_i;
            fc_ic_cancel_o        = ic_miss_i;
          end else if (load_use) begin
            fc_hold_pc_o      = 1'b1;
            fc_hold_if_id_o   = 1'b1;
            fc_bubble_id_ex_o = 1'b1;
          end else if (ic_miss_i) begin
            fc_hold_pc_o = 1'b1;
            state_nxt    = IMISS;
          end
        end
        DMISS: begin
          {fc_hold_pc_o, fc_hold_if_id_o, fc_hold_id_ex_o, fc_hold_ex_mem_o} = 4'b1111;
          if (dc_refill_done_i) state_nxt = RUN;
        end
        IMISS: begin
          if (mem_dc_miss_i) begin
            {fc_hold_pc_o, fc_hold_if_id_o, fc_hold_id_ex_o, fc_hold_ex_mem_o} = 4'b1111;
            state_nxt = DMISS;
          end else if (redirect) begin
            fc_flush_btype_flag_o = ex_branch_taken_i;
            fc_flush_jtype_flag_o = !ex_branch_taken_i;
            fc_redirect_pc_o      = ex_target_i;
            fc_ic_cancel_o        = 1'b1;
            state_nxt             = RUN;
          end else begin
            fc_hold_pc_o = 1'b1;
            if (load_use) begin
              fc_hold_if_id_o   = 1'b1;
              fc_bubble_id_ex_o = 1'b1;
            end
            if (ic_refill_done_i) state_nxt = RUN;
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= RUN;
      wd_cnt         <= '0;
      fc_err_o       <= 1'b0;
      fc_stall_cnt_o <= '0;
    end else begin
      state <= state_nxt;
      if (state == RUN) begin
        wd_cnt <= '0;
      end else begin
        if (wd_cnt != WD_MAX) wd_cnt <= wd_cnt + 1'b1;
        if (wd_cnt + 1'b1 == WD_MAX) fc_err_o <= 1'b1;
      end
      if (any_hold && (fc_stall_cnt_o != '1)) fc_stall_cnt_o <= fc_stall_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_flow_ctrl.sv
// Directed bench for flow_ctrl: per-cycle expectations are queued by the driver
// and checked by an independent negedge monitor.
module tb_flow_ctrl;

  localparam int W = 75;
  localparam logic [7:0] C_NONE  = 8'b0000_0000;
  localparam logic [7:0] C_HOLD4 = 8'b1111_0000;
  localparam logic [7:0] C_LU    = 8'b1100_1000;
  localparam logic [7:0] C_HPC   = 8'b1000_0000;
  localparam logic [7:0] C_FB    = 8'b0000_0100;
  localparam logic [7:0] C_FBC   = 8'b0000_0101;
  localparam logic [7:0] C_FJ    = 8'b0000_0010;
  localparam logic [7:0] C_FJC   = 8'b0000_0011;
  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_DMISS = 2'd1;
  localparam logic [1:0] S_IMISS = 2'd2;

  typedef struct packed {
    logic        rst;
    logic        br;
    logic        jp;
    logic [31:0] tgt;
    logic        ld;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        u1;
    logic        u2;
    logic        dcm;
    logic        dcd;
    logic        icm;
    logic        icd;
  } in_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        ex_branch_taken_i, ex_jump_i, ex_is_load_i;
  logic [31:0] ex_target_i;
  logic [4:0]  ex_rd_i, id_rs1_i, id_rs2_i;
  logic        id_rs1_used_i, id_rs2_used_i;
  logic        mem_dc_miss_i, dc_refill_done_i, ic_miss_i, ic_refill_done_i;
  logic        fc_hold_pc_o, fc_hold_if_id_o, fc_hold_id_ex_o, fc_hold_ex_mem_o;
  logic        fc_bubble_id_ex_o, fc_flush_btype_flag_o, fc_flush_jtype_flag_o;
  logic [31:0] fc_redirect_pc_o;
  logic        fc_ic_cancel_o, fc_err_o;
  logic [31:0] fc_stall_cnt_o;
  logic [1:0]  fc_state_o;

  flow_ctrl #(.MISS_TIMEOUT(16), .CNT_W(32)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .ex_branch_taken_i     (ex_branch_taken_i),
    .ex_jump_i             (ex_jump_i),
    .ex_target_i           (ex_target_i),
    .ex_is_load_i          (ex_is_load_i),
    .ex_rd_i               (ex_rd_i),
    .id_rs1_i              (id_rs1_i),
    .id_rs2_i              (id_rs2_i),
    .id_rs1_used_i         (id_rs1_used_i),
    .id_rs2_used_i         (id_rs2_used_i),
    .mem_dc_miss_i         (mem_dc_miss_i),
    .dc_refill_done_i      (dc_refill_done_i),
    .ic_miss_i             (ic_miss_i),
    .ic_refill_done_i      (ic_refill_done_i),
    .fc_hold_pc_o          (fc_hold_pc_o),
    .fc_hold_if_id_o       (fc_hold_if_id_o),
    .fc_hold_id_ex_o       (fc_hold_id_ex_o),
    .fc_hold_ex_mem_o      (fc_hold_ex_mem_o),
    .fc_bubble_id_ex_o     (fc_bubble_id_ex_o),
    .fc_flush_btype_flag_o (fc_flush_btype_flag_o),
    .fc_flush_jtype_flag_o (fc_flush_jtype_flag_o),
    .fc_redirect_pc_o      (fc_redirect_pc_o),
    .fc_ic_cancel_o        (fc_ic_cancel_o),
    .fc_err_o              (fc_err_o),
    .fc_stall_cnt_o        (fc_stall_cnt_o),
    .fc_state_o            (fc_state_o)
  );

  // scoreboard
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           checks = 0;
  int           errors = 0;
  logic [31:0]  exp_cnt = 32'd0;
  logic         exp_err = 1'b0;

  function automatic in_t idle();
    in_t v;
    v = '0;
    v.rst = 1'b1;
    return v;
  endfunction

  task automatic apply(input in_t v);
    rst_n             = v.rst;
    ex_branch_taken_i = v.br;
    ex_jump_i         = v.jp;
    ex_target_i       = v.tgt;
    ex_is_load_i      = v.ld;
    ex_rd_i           = v.rd;
    id_rs1_i          = v.rs1;
    id_rs2_i          = v.rs2;
    id_rs1_used_i     = v.u1;
    id_rs2_used_i     = v.u2;
    mem_dc_miss_i     = v.dcm;
    dc_refill_done_i  = v.dcd;
    ic_miss_i         = v.icm;
    ic_refill_done_i  = v.icd;
  endtask

  // driver: one cycle of stimulus plus the expected outputs for that cycle
  task automatic cyc(input string nm, input in_t v, input logic [7:0] ctl,
                     input logic [1:0] st, input logic [31:0] pc);
    @(posedge clk);
    #1;
    apply(v);
    if (!v.rst) begin
      exp_cnt = 32'd0;
      exp_err = 1'b0;
    end
    exp_q.push_back({ctl, exp_err, st, pc, exp_cnt});
    name_q.push_back(nm);
    if (v.rst && (ctl[7:4] != 4'b0000)) exp_cnt = exp_cnt + 32'd1;
  endtask

  // monitor
  always @(negedge clk) begin
    logic [W-1:0] e;
    logic [W-1:0] a;
    string        nm;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = {fc_hold_pc_o, fc_hold_if_id_o, fc_hold_id_ex_o, fc_hold_ex_mem_o,
            fc_bubble_id_ex_o, fc_flush_btype_flag_o, fc_flush_jtype_flag_o,
            fc_ic_cancel_o, fc_err_o, fc_state_o, fc_redirect_pc_o, fc_stall_cnt_o};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got ctl=%b err=%b st=%0d pc=%h cnt=%0d, expected ctl=%b err=%b st=%0d pc=%h cnt=%0d",
                 nm, a[74:67], a[66], a[65:64], a[63:32], a[31:0],
                 e[74:67], e[66], e[65:64], e[63:32], e[31:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    in_t v;
    v = idle();
    apply(v);
    #2;
    rst_n = 1'b0;

    v = idle(); v.rst = 1'b0;
    cyc("reset", v, C_NONE, S_RUN, 32'h0);
    cyc("reset", v, C_NONE, S_RUN, 32'h0);
    v = idle();
    cyc("idle", v, C_NONE, S_RUN, 32'h0);

    // load-use hazards
    v = idle(); v.ld = 1; v.rd = 5'd5; v.rs2 = 5'd5; v.u2 = 1; v.rs1 = 5'd3; v.u1 = 1;
    cyc("load_use", v, C_LU, S_RUN, 32'h0);
    v = idle();
    cyc("lu_release", v, C_NONE, S_RUN, 32'h0);
    v = idle(); v.ld = 1; v.rd = 5'd0; v.rs1 = 5'd0; v.u1 = 1;
    cyc("lu_x0", v, C_NONE, S_RUN, 32'h0);
    v = idle(); v.ld = 1; v.rd = 5'd7; v.rs2 = 5'd7; v.u2 = 0;
    cyc("lu_unused", v, C_NONE, S_RUN, 32'h0);
    v = idle(); v.rd = 5'd7; v.rs1 = 5'd7; v.u1 = 1;
    cyc("no_load", v, C_NONE, S_RUN, 32'h0);
    v = idle(); v.ld = 1; v.rd = 5'd9; v.rs1 = 5'd9; v.u1 = 1;
    cyc("lu_rs1", v, C_LU, S_RUN, 32'h0);

    // redirects
    v = idle(); v.br = 1; v.tgt = 32'h0000_0400;
    cyc("branch", v, C_FB, S_RUN, 32'h400);
    v.jp = 1;
    cyc("br_and_jump", v, C_FB, S_RUN, 32'h400);
    v = idle(); v.jp = 1; v.tgt = 32'h0000_0800;
    cyc("jump", v, C_FJ, S_RUN, 32'h800);
    v = idle(); v.br = 1; v.tgt = 32'h0000_0123; v.ld = 1; v.rd = 5'd4; v.rs1 = 5'd4; v.u1 = 1;
    cyc("br_over_lu", v, C_FB, S_RUN, 32'h123);
    v = idle(); v.br = 1; v.tgt = 32'h0000_0200; v.icm = 1;
    cyc("br_ic_cancel", v, C_FBC, S_RUN, 32'h200);
    v = idle();
    cyc("after_cancel", v, C_NONE, S_RUN, 32'h0);

    // D-cache miss: 10 miss cycles plus the refill cycle, branch blocked throughout
    v = idle(); v.dcm = 1; v.br = 1; v.tgt = 32'h0000_0044;
    cyc("dmiss_enter", v, C_HOLD4, S_RUN, 32'h0);
    for (int i = 0; i < 9; i++) cyc("dmiss_hold", v, C_HOLD4, S_DMISS, 32'h0);
    v.dcd = 1;
    cyc("dmiss_done", v, C_HOLD4, S_DMISS, 32'h0);
    v = idle(); v.br = 1; v.tgt = 32'h0000_0044;
    cyc("dmiss_replay", v, C_FB, S_RUN, 32'h44);

    // I-cache miss cancelled by a jump
    v = idle(); v.icm = 1;
    cyc("imiss_enter", v, C_HPC, S_RUN, 32'h0);
    cyc("imiss_wait", v, C_HPC, S_IMISS, 32'h0);
    cyc("imiss_wait", v, C_HPC, S_IMISS, 32'h0);
    v.jp = 1; v.tgt = 32'h0000_0080;
    cyc("imiss_jump", v, C_FJC, S_IMISS, 32'h80);
    v = idle();
    cyc("imiss_exit", v, C_NONE, S_RUN, 32'h0);

    // I-cache miss with load-use inside, then normal refill
    v = idle(); v.icm = 1;
    cyc("imiss2_enter", v, C_HPC, S_RUN, 32'h0);
    v.ld = 1; v.rd = 5'd6; v.rs2 = 5'd6; v.u2 = 1;
    cyc("imiss_lu", v, C_LU, S_IMISS, 32'h0);
    v = idle(); v.icd = 1;
    cyc("imiss_done", v, C_HPC, S_IMISS, 32'h0);
    v = idle();
    cyc("imiss_back", v, C_NONE, S_RUN, 32'h0);

    // D-cache miss taking over an I-cache miss
    v = idle(); v.icm = 1;
    cyc("imiss3_enter", v, C_HPC, S_RUN, 32'h0);
    v.dcm = 1;
    cyc("imiss_dmiss", v, C_HOLD4, S_IMISS, 32'h0);
    v = idle(); v.dcd = 1;
    cyc("i2d_done", v, C_HOLD4, S_DMISS, 32'h0);
    v = idle();
    cyc("i2d_back", v, C_NONE, S_RUN, 32'h0);

    // watchdog: 16 cycles in DMISS without a refill
    v = idle(); v.rst = 0;
    cyc("wd_reset", v, C_NONE, S_RUN, 32'h0);
    v = idle(); v.dcm = 1;
    cyc("wd_enter", v, C_HOLD4, S_RUN, 32'h0);
    for (int i = 0; i < 16; i++) cyc("wd_count", v, C_HOLD4, S_DMISS, 32'h0);
    exp_err = 1'b1;
    for (int i = 0; i < 3; i++) cyc("wd_err", v, C_HOLD4, S_DMISS, 32'h0);
    v = idle();
    cyc("wd_sticky", v, C_HOLD4, S_DMISS, 32'h0);
    v.rst = 0;
    cyc("wd_clear", v, C_NONE, S_RUN, 32'h0);

    // reset on cycle 4 of a miss, refill pulse afterwards ignored
    v = idle();
    cyc("rm_idle", v, C_NONE, S_RUN, 32'h0);
    v.dcm = 1;
    cyc("rm_enter", v, C_HOLD4, S_RUN, 32'h0);
    for (int i = 0; i < 2; i++) cyc("rm_hold", v, C_HOLD4, S_DMISS, 32'h0);
    v.rst = 0;
    cyc("rm_reset", v, C_NONE, S_RUN, 32'h0);
    v.dcm = 0;
    cyc("rm_reset_hold", v, C_NONE, S_RUN, 32'h0);
    v = idle(); v.dcd = 1;
    cyc("rm_refill", v, C_NONE, S_RUN, 32'h0);
    v = idle();
    cyc("rm_after", v, C_NONE, S_RUN, 32'h0);

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
